utx_fifo_drain: RTL and testbench

- Consumer stage downstream of the transmit FIFO (ufifo).
- Pulls bytes from the FIFO read port and serialises them onto the UART TX line.
- Frame is 8N1, with optional parity; CLKS_PER_BAUD clocks per bit.
- Honours hardware flow control (CTS) at frame boundaries.

---
 rtl/utx_fifo_drain_if.sv | 12 +
 rtl/utx_fifo_drain.sv | 167 ++++++++++++++++
 tb/tb_utx_fifo_drain.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/utx_fifo_drain_if.sv
// FIFO read-port bundle between the ufifo transmit queue and utx_fifo_drain.
// Signal names are seen from the drain stage: it consumes i_empty_n/i_data and produces o_rd.
interface utx_fifo_drain_if;
   logic       i_empty_n;
   logic [7:0] i_data;
   logic       o_rd;

   // FIFO side: presents the head byte and accepts pops
   modport master (output i_empty_n, output i_data, input o_rd);
   // Drain side: observes the head byte and issues pops
   modport slave  (input i_empty_n, input i_data, output o_rd);
endinterface

// File: rtl/utx_fifo_drain.sv
// utx_fifo_drain: pops bytes from the TX FIFO and serialises them as UART frames
// (start, 8 data bits LSB first, optional parity, stop), honouring CTS at frame boundaries.
// Optional feature macro: UTX_PARITY_EN inserts a parity bit (odd when PARITY_ODD=1, else even).
module utx_fifo_drain #(
   parameter int unsigned CLKS_PER_BAUD = 868,
   parameter int unsigned PARITY_ODD    = 0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   utx_fifo_drain_if.slave fifo,
   input  logic            i_cts_n,
   output logic            o_uart_tx,
   output logic            o_busy
);

   localparam int unsigned            CNT_W       = 24;
   localparam logic [CNT_W-1:0]       BAUD_RELOAD = CNT_W'(CLKS_PER_BAUD - 1);

   // Reject parameter values the counter or parity select cannot represent
   if ((CLKS_PER_BAUD < 2) || (CLKS_PER_BAUD > ((2 ** CNT_W) - 1))) begin : g_bad_baud
      $error("utx_fifo_drain: CLKS_PER_BAUD out of range 2..2^24-1");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity
      $error("utx_fifo_drain: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UTX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_cts_s1;
   logic             r_cts_s2;
`ifdef UTX_PARITY_EN
   logic             r_parity;
`endif

   logic w_baud_zero;
   logic w_start_ok;
   logic w_load;

   assign w_baud_zero = (r_baud_cnt == '0);
   // A byte is waiting and the far end is clear to receive
   assign w_start_ok  = fifo.i_empty_n & ~r_cts_s2;
   // Frame launch point: idle, or the final clock of a stop bit (back-to-back)
   assign w_load      = w_start_ok &
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_zero));

   // Two-flop synchroniser for the asynchronous CTS input
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cts_s1 <= 1'b1;
         r_cts_s2 <= 1'b1;
      end else begin
         r_cts_s1 <= i_cts_n;
         r_cts_s2 <= r_cts_s1;
      end
   end

   // Frame sequencer: baud timing, bit shifting and registered line/pop/busy outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         o_uart_tx  <= 1'b1;
         fifo.o_rd  <= 1'b0;
         o_busy     <= 1'b0;
`ifdef UTX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         fifo.o_rd <= 1'b0;

         if (w_load) begin
            // Latch the head byte, pop it and drive the start bit on the same edge
            r_shift    <= fifo.i_data;
            fifo.o_rd  <= 1'b1;
            o_uart_tx  <= 1'b0;
            o_busy     <= 1'b1;
            r_baud_cnt <= BAUD_RELOAD;
            r_state    <= S_START;
`ifdef UTX_PARITY_EN
            r_parity   <= (^fifo.i_data) ^ PARITY_ODD[0];
`endif
         end else begin
            if (r_state != S_IDLE) begin
               if (w_baud_zero) begin
                  r_baud_cnt <= BAUD_RELOAD;
               end else begin
                  r_baud_cnt <= r_baud_cnt - CNT_W'(1);
               end
            end

            case (r_state)
               S_IDLE: begin
                  o_uart_tx <= 1'b1;
               end

               S_START: begin
                  if (w_baud_zero) begin
                     o_uart_tx <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_idx <= '0;
                     r_state   <= S_DATA;
                  end
               end

               S_DATA: begin
                  if (w_baud_zero) begin
                     if (r_bit_idx == 3'd7) begin
`ifdef UTX_PARITY_EN
                        o_uart_tx <= r_parity;
                        r_state   <= S_PARITY;
`else
                        o_uart_tx <= 1'b1;
                        r_state   <= S_STOP;
`endif
                     end else begin
                        o_uart_tx <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end
               end

`ifdef UTX_PARITY_EN
               S_PARITY: begin
                  if (w_baud_zero) begin
                     o_uart_tx <= 1'b1;
                     r_state   <= S_STOP;
                  end
               end
`endif

               S_STOP: begin
                  // A back-to-back start is handled by w_load; otherwise go idle here
                  if (w_baud_zero) begin
                     o_uart_tx  <= 1'b1;
                     o_busy     <= 1'b0;
                     r_baud_cnt <= '0;
                     r_state    <= S_IDLE;
                  end
               end

               default: begin
                  o_uart_tx  <= 1'b1;
                  o_busy     <= 1'b0;
                  r_baud_cnt <= '0;
                  r_state    <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_utx_fifo_drain.sv
// Self-checking bench for utx_fifo_drain: a FIFO model feeds the DUT, expected bytes are
// queued as they are offered, and a line monitor decodes each serial frame and scores it.
module tb_utx_fifo_drain;

   localparam int unsigned CPB     = 4;
   localparam int unsigned PAR_ODD = 0;
`ifdef UTX_PARITY_EN
   localparam int unsigned NBITS   = 11;
`else
   localparam int unsigned NBITS   = 10;
`endif
   localparam int unsigned FRAME_CLKS = NBITS * CPB;

   logic i_clk = 1'b0;
   logic i_rst;
   logic i_cts_n;
   logic o_uart_tx;
   logic o_busy;

   utx_fifo_drain_if fif ();

   utx_fifo_drain #(
      .CLKS_PER_BAUD (CPB),
      .PARITY_ODD    (PAR_ODD)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .fifo      (fif),
      .i_cts_n   (i_cts_n),
      .o_uart_tx (o_uart_tx),
      .o_busy    (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int         checks;
   int         failures;
   int         cyc;
   int         rd_cnt;
   int         frames;
   int         busy_run;
   int         last_busy_len;
   int         fcnt;
   bit         in_frame;
   bit         busy_ok;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         rd_cyc[$];
   int         start_cyc[$];
   logic       samp[0:FRAME_CLKS-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Expected line level for bit slot idx of a frame carrying byte b
   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UTX_PARITY_EN
      if (idx == 9) return ((($countones(b) % 2) == 1) ? 1'b1 : 1'b0) ^ (PAR_ODD != 0);
`endif
      return 1'b1;
   endfunction

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
   endtask

   // FIFO head presentation: updates away from the active edge
   task automatic fifo_drive();
      forever begin
         @(negedge i_clk);
         fif.i_empty_n = (fifo_q.size() != 0);
         fif.i_data    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      end
   endtask

   // Line monitor and scoreboard
   task automatic monitor();
      logic [7:0] eb;
      logic [3:0] got;
      logic       e;
      forever begin
         @(posedge i_clk);
         #1;
         cyc++;
         if (i_rst) begin
            in_frame = 0;
            busy_run = 0;
            chk("rst_tx", o_uart_tx, 1);
            chk("rst_busy", o_busy, 0);
            chk("rst_rd", fif.o_rd, 0);
            continue;
         end
         if (fif.o_rd === 1'b1) begin
            chk("rd_nonempty", fif.i_empty_n, 1);
            rd_cnt++;
            rd_cyc.push_back(cyc);
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         end
         if (o_busy === 1'b1) begin
            busy_run++;
         end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
         end
         if (!in_frame && (o_uart_tx === 1'b0)) begin
            in_frame = 1;
            fcnt     = 0;
            busy_ok  = 1;
            start_cyc.push_back(cyc);
         end
         if (in_frame) begin
            samp[fcnt] = o_uart_tx;
            if (o_busy !== 1'b1) busy_ok = 0;
            if (fcnt == FRAME_CLKS - 1) begin
               in_frame = 0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 1, 0);
               end else begin
                  eb = exp_q.pop_front();
                  for (int b = 0; b < NBITS; b++) begin
                     for (int k = 0; k < CPB; k++) got[k] = samp[b*CPB + k];
                     e = exp_bit(eb, b);
                     chk($sformatf("frame%0d_byte%02h_slot%0d", frames, eb, b), 32'(got), 32'({4{e}}));
                  end
                  chk($sformatf("frame%0d_busy", frames), 32'(busy_ok), 1);
               end
               frames++;
            end else begin
               fcnt++;
            end
         end
      end
   endtask

   task automatic wait_idle(input int bound, input string name);
      bit done;
      done = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge i_clk);
         if ((exp_q.size() == 0) && (o_busy === 1'b0) && !in_frame) begin
            done = 1;
            break;
         end
      end
      chk({name, "_drain_timeout"}, 32'(done), 1);
   endtask

   initial begin
      int r0;
      int s0;
      int drop_cyc;
      bit ok;
      checks = 0; failures = 0; cyc = 0; rd_cnt = 0; frames = 0;
      busy_run = 0; last_busy_len = 0; fcnt = 0; in_frame = 0; busy_ok = 0;
      i_rst = 1'b1;
      i_cts_n = 1'b1;
      fif.i_empty_n = 1'b0;
      fif.i_data = 8'h00;
      fork
         monitor();
         fifo_drive();
      join_none

      // Reset, then idle with an empty FIFO
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      ok = 1;
      repeat (20) begin
         @(negedge i_clk);
         if ((o_uart_tx !== 1'b1) || (fif.o_rd !== 1'b0) || (o_busy !== 1'b0)) ok = 0;
      end
      chk("t1_idle_quiet", 32'(ok), 1);

      // Single byte
      i_cts_n = 1'b0;
      r0 = rd_cnt;
      push(8'h55);
      wait_idle(200, "t2");
      chk("t2_rd_pulses", 32'(rd_cnt - r0), 1);
      chk("t2_busy_len", 32'(last_busy_len), FRAME_CLKS);

      // CTS blocks, then two back-to-back frames
      i_cts_n = 1'b1;
      repeat (3) @(negedge i_clk);
      r0 = rd_cnt;
      s0 = start_cyc.size();
      push(8'hA3);
      push(8'h0F);
      ok = 1;
      repeat (12) begin
         @(negedge i_clk);
         if (o_uart_tx !== 1'b1) ok = 0;
      end
      chk("t3_cts_block_line", 32'(ok), 1);
      chk("t3_cts_block_rd", 32'(rd_cnt - r0), 0);
      @(negedge i_clk);
      drop_cyc = cyc;
      i_cts_n = 1'b0;
      wait_idle(400, "t3");
      chk("t3_rd_pulses", 32'(rd_cnt - r0), 2);
      if (rd_cyc.size() >= r0 + 2)
         chk("t3_rd_gap", 32'(rd_cyc[r0+1] - rd_cyc[r0]), FRAME_CLKS);
      if (start_cyc.size() >= s0 + 2) begin
         chk("t3_cts_latency", 32'(start_cyc[s0] - drop_cyc), 3);
         chk("t3_back_to_back", 32'(start_cyc[s0+1] - start_cyc[s0]), FRAME_CLKS);
      end
      chk("t3_busy_len", 32'(last_busy_len), 2 * FRAME_CLKS);

      // CTS raised mid-frame: current frame completes, next is held
      i_cts_n = 1'b1;
      repeat (3) @(negedge i_clk);
      r0 = rd_cnt;
      s0 = start_cyc.size();
      push(8'h3C);
      @(negedge i_clk);
      drop_cyc = cyc;
      i_cts_n = 1'b0;
      repeat (10) @(negedge i_clk);
      push(8'hC3);
      i_cts_n = 1'b1;
      repeat (FRAME_CLKS + 30) @(negedge i_clk);
      chk("t4_rd_held", 32'(rd_cnt - r0), 1);
      chk("t4_fifo_kept", 32'(fifo_q.size()), 1);
      chk("t4_line_idle", o_uart_tx, 1);
      chk("t4_busy_low", o_busy, 0);
      chk("t4_exp_left", 32'(exp_q.size()), 1);
      if (start_cyc.size() > s0)
         chk("t4_cts_latency", 32'(start_cyc[s0] - drop_cyc), 3);
      i_cts_n = 1'b0;
      wait_idle(200, "t4");
      chk("t4_rd_resumed", 32'(rd_cnt - r0), 2);

      // Parity-relevant and boundary bytes back to back
      push(8'h07);
      push(8'h00);
      push(8'hFF);
      wait_idle(400, "t5");
      chk("t5_busy_len", 32'(last_busy_len), 3 * FRAME_CLKS);

      // Reset during data bit 3
      r0 = rd_cnt;
      push(8'h96);
      push(8'h5A);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge i_clk);
         if (rd_cnt != r0) begin
            ok = 1;
            break;
         end
      end
      chk("t6_first_pop", 32'(ok), 1);
      repeat (17) @(negedge i_clk);
      void'(exp_q.pop_front());
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("t6_tx_after_rst", o_uart_tx, 1);
      chk("t6_busy_after_rst", o_busy, 0);
      chk("t6_fifo_retained", 32'(fifo_q.size()), 1);
      i_rst = 1'b0;
      wait_idle(200, "t6");
      chk("t6_rd_pulses", 32'(rd_cnt - r0), 2);

      // Randomised bytes, gaps and CTS stalls
      r0 = rd_cnt;
      for (int n = 0; n < 12; n++) begin
         push(8'($urandom));
         repeat ($urandom_range(0, 30)) @(negedge i_clk);
         if ($urandom_range(0, 3) == 0) begin
            i_cts_n = 1'b1;
            repeat ($urandom_range(5, 60)) @(negedge i_clk);
            i_cts_n = 1'b0;
         end
      end
      wait_idle(12 * FRAME_CLKS * 3 + 1000, "t7");
      chk("t7_rd_pulses", 32'(rd_cnt - r0), 12);
      chk("final_fifo_empty", 32'(fifo_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
